// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch unit:
// FSM state enum, word type and default PC parameters.
package if_fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY,
    DROP
  } state_e;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle.
// master: imem_req/imem_addr out, imem_ack/imem_rdata in.
interface if_fetch_unit_if;
  import if_fetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_perf_counters.sv
// Fetch/drop event counters, present only with IF_PERF_CNT_EN.
// In: consume_i, drop_i strobes. Out: fetch_count_o, drop_count_o.
`ifdef IF_PERF_CNT_EN
module if_perf_counters
  import if_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  consume_i,
  input  logic  drop_i,
  output word_t fetch_count_o,
  output word_t drop_count_o
);

  word_t fetch_q;
  word_t drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q <= '0;
      drop_q  <= '0;
    end else begin
      if (consume_i) fetch_q <= fetch_q + 32'd1;
      if (drop_i)    drop_q  <= drop_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_q;
  assign drop_count_o  = drop_q;

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// Fetch engine: PC, imem requests, 1-entry buffer, branch redirect.
// Ports: clk, rst(async low), Freeze, Branch_*, imem (master),
// Instruction_out, PC_out, Valid_out, Flush_out.
// IF_PERF_CNT_EN adds Fetch_count/Drop_count outputs.
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter word_t PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  Freeze,
  input  logic  Branch_taken,
  input  word_t Branch_addr,
  if_fetch_unit_if.master imem,
  output word_t Instruction_out,
  output word_t PC_out,
  output logic  Valid_out,
`ifdef IF_PERF_CNT_EN
  output word_t Fetch_count,
  output word_t Drop_count,
`endif
  output logic  Flush_out
);

  state_e state_q;
  word_t  pc_q;
  word_t  addr_q;
  word_t  inst_q;
  word_t  pcp_q;
  logic   valid_q;
  logic   req_q;
  word_t  pc_inc;

  assign pc_inc = pc_q + PC_STEP;

  // A branch never cancels an issued request: from FETCH
  // without ack we park in DROP with addr_q frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= '0;
      pcp_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else if (Branch_taken) begin
      pc_q    <= Branch_addr;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) addr_q  <= Branch_addr;
          else               state_q <= DROP;
        end
        DROP: begin
          if (imem.imem_ack) begin
            addr_q  <= Branch_addr;
            state_q <= FETCH;
          end
        end
        default: begin
          addr_q  <= Branch_addr;
          state_q <= FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_q  <= pc_q;
          req_q   <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            inst_q  <= imem.imem_rdata;
            pcp_q   <= pc_inc;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= READY;
          end
        end
        READY: begin
          if (!Freeze) begin
            pc_q    <= pc_inc;
            addr_q  <= pc_inc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (imem.imem_ack) begin
            addr_q  <= pc_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign Instruction_out = inst_q;
  assign PC_out          = pcp_q;
  assign Valid_out       = valid_q;
  assign Flush_out       = Branch_taken;

`ifdef IF_PERF_CNT_EN
  logic consume;
  logic drop;

  assign consume = (state_q == READY) && !Freeze
                 && !Branch_taken;
  assign drop = imem.imem_ack
              && ((state_q == DROP)
              || ((state_q == FETCH) && Branch_taken));

  if_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .consume_i    (consume),
    .drop_i       (drop),
    .fetch_count_o(Fetch_count),
    .drop_count_o (Drop_count)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a scripted imem.
// Build with +define+IF_PERF_CNT_EN to cover counters.
module tb_if_fetch_unit;
  import if_fetch_pkg::*;

  logic  clk;
  logic  rst;
  logic  Freeze;
  logic  Branch_taken;
  word_t Branch_addr;
  word_t Instruction_out;
  word_t PC_out;
  logic  Valid_out;
  logic  Flush_out;
`ifdef IF_PERF_CNT_EN
  word_t Fetch_count;
  word_t Drop_count;
`endif

  if_fetch_unit_if mif ();

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .Freeze         (Freeze),
    .Branch_taken   (Branch_taken),
    .Branch_addr    (Branch_addr),
    .imem           (mif),
    .Instruction_out(Instruction_out),
    .PC_out         (PC_out),
    .Valid_out      (Valid_out),
`ifdef IF_PERF_CNT_EN
    .Fetch_count    (Fetch_count),
    .Drop_count     (Drop_count),
`endif
    .Flush_out      (Flush_out)
  );

  typedef struct {
    word_t inst;
    word_t pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_fetch = 0;
  int   exp_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input word_t a);
    int n = 0;
    while (!mif.imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(mif.imem_req), 32'd1);
    chk("req_addr", mif.imem_addr, a);
  endtask

  task automatic serve(input word_t a, input int lat,
                       input word_t d);
    exp_t e;
    wait_req(a);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("addr_hold", mif.imem_addr, a);
      chk("req_hold", 32'(mif.imem_req), 32'd1);
    end
    e.inst = d;
    e.pc   = a + 32'd4;
    sb.push_back(e);
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = d;
    tick();
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = '0;
  endtask

  task automatic expect_out();
    exp_t e;
    chk("valid", 32'(Valid_out), 32'd1);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", Instruction_out, e.inst);
      chk("pc_out", PC_out, e.pc);
    end
  endtask

  task automatic take();
    expect_out();
    chk("req_ready", 32'(mif.imem_req), 32'd0);
    tick();
    exp_fetch++;
  endtask

  task automatic chk_perf();
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", Fetch_count, 32'(exp_fetch));
    chk("drop_cnt", Drop_count, 32'(exp_drop));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    Freeze         = 1'b0;
    Branch_taken   = 1'b0;
    Branch_addr    = '0;
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mif.imem_req), 32'd0);
    chk("rst_valid", 32'(Valid_out), 32'd0);
    chk("rst_flush", 32'(Flush_out), 32'd0);
    chk("rst_addr", mif.imem_addr, 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk_perf();
    rst = 1'b1;

    serve(32'h0, 1, 32'h0000_0013);
    take();

    serve(32'h4, 1, 32'h2002_000A);
    Freeze = 1'b1;
    expect_out();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_valid", 32'(Valid_out), 32'd1);
      chk("frz_inst", Instruction_out, 32'h2002_000A);
      chk("frz_pc", PC_out, 32'h8);
      chk("frz_req", 32'(mif.imem_req), 32'd0);
    end
    Freeze = 1'b0;
    tick();
    exp_fetch++;
    chk("unfrz_req", 32'(mif.imem_req), 32'd1);
    chk("unfrz_addr", mif.imem_addr, 32'h8);

    serve(32'h8, 0, 32'h0030_0193);
    take();
    serve(32'hC, 2, 32'h0040_0213);
    take();

    // branch while request to 0x10 waits 3 cycles
    wait_req(32'h10);
    tick();
    Branch_taken = 1'b1;
    Branch_addr  = 32'h40;
    #1;
    chk("b1_flush", 32'(Flush_out), 32'd1);
    tick();
    Branch_taken = 1'b0;
    chk("b1_valid", 32'(Valid_out), 32'd0);
    chk("b1_addr", mif.imem_addr, 32'h10);
    chk("b1_flush0", 32'(Flush_out), 32'd0);
    tick();
    chk("b1_addr2", mif.imem_addr, 32'h10);
    chk("b1_req", 32'(mif.imem_req), 32'd1);
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = 32'hDEAD_BEEF;
    tick();
    mif.imem_ack = 1'b0;
    exp_drop++;
    chk("b1_dropv", 32'(Valid_out), 32'd0);
    chk("b1_next", mif.imem_addr, 32'h40);
    serve(32'h40, 1, 32'h0050_0293);
    take();

    // branch coinciding with ack
    wait_req(32'h44);
    Branch_taken   = 1'b1;
    Branch_addr    = 32'h80;
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("b2_flush", 32'(Flush_out), 32'd1);
    tick();
    Branch_taken = 1'b0;
    mif.imem_ack = 1'b0;
    exp_drop++;
    chk("b2_valid", 32'(Valid_out), 32'd0);
    chk("b2_addr", mif.imem_addr, 32'h80);
    chk("b2_req", 32'(mif.imem_req), 32'd1);
    serve(32'h80, 0, 32'h0060_0313);
    take();

    // two branches over one outstanding request
    wait_req(32'h84);
    Branch_taken = 1'b1;
    Branch_addr  = 32'h100;
    tick();
    Branch_addr = 32'h200;
    chk("b3_addr", mif.imem_addr, 32'h84);
    chk("b3_valid", 32'(Valid_out), 32'd0);
    tick();
    Branch_taken = 1'b0;
    chk("b3_addr2", mif.imem_addr, 32'h84);
    mif.imem_ack = 1'b1;
    tick();
    mif.imem_ack = 1'b0;
    exp_drop++;
    chk("b3_next", mif.imem_addr, 32'h200);
    chk("b3_dropv", 32'(Valid_out), 32'd0);
    serve(32'h200, 1, 32'h0070_0393);
    take();

    // redirect from READY to the top of memory, then wrap
    serve(32'h204, 0, 32'h0080_0413);
    expect_out();
    Branch_taken = 1'b1;
    Branch_addr  = 32'hFFFF_FFFC;
    tick();
    Branch_taken = 1'b0;
    chk("b4_valid", 32'(Valid_out), 32'd0);
    chk("b4_addr", mif.imem_addr, 32'hFFFF_FFFC);
    serve(32'hFFFF_FFFC, 2, 32'h0090_0493);
    take();
    serve(32'h0, 0, 32'h00A0_0513);
    take();
    chk_perf();

    // asynchronous reset abandons the request
    wait_req(32'h4);
    rst = 1'b0;
    #1;
    chk("ar_req", 32'(mif.imem_req), 32'd0);
    chk("ar_valid", 32'(Valid_out), 32'd0);
    chk("ar_addr", mif.imem_addr, 32'h0);
    exp_fetch = 0;
    exp_drop  = 0;
    chk_perf();
    tick();
    rst = 1'b1;
    serve(32'h0, 1, 32'h00B0_0593);
    take();
    chk_perf();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
